// File: rtl/store_unit.sv
// store_unit
// ----------
// Write-side counterpart of the core's load path. Accepts one store per
// handshake from the execute stage, lane-replicates the store data, builds the
// byte-enable mask, rejects misaligned stores, and runs a single-outstanding
// request/acknowledge transaction to data memory guarded by a watchdog.
//
// Ports
//   clk_in          core clock, all state changes on the rising edge
//   rst_in          synchronous, active-low reset
//   st_valid_in     store presented this cycle
//   st_size_in      00 byte, 01 halfword, 10 word, 11 reserved (as word)
//   iadder_in       effective byte address
//   rs2_in          store data, value in the low bits
//   st_ready_out    store accepted when high together with st_valid_in
//   stall_out       st_valid_in & ~st_ready_out
//   dmwr_req_out    write request to data memory
//   dmaddr_out      word address of the pending write
//   dmdata_out      lane-replicated write data
//   dmwr_mask_out   byte enables, bit n covers dmdata_out[8n+7:8n]
//   dmwr_ack_in     memory committed the write (only looked at while requesting)
//   misaligned_out  one-cycle pulse: store rejected for misalignment
//   bus_error_out   one-cycle pulse: store aborted by the watchdog
//   dbg_state_out   current FSM state (0 IDLE, 1 WAIT)
//
// Handshakes
//   Execute side: a store transfers on a rising edge where st_valid_in and
//   st_ready_out are both high. st_ready_out is 1 in IDLE, follows
//   dmwr_ack_in in WAIT, and is 0 while reset is asserted.
//   Memory side: dmwr_req_out and the address/data/mask stay stable until an
//   edge where dmwr_ack_in is high (write done) or the watchdog expires.

module store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_valid_in,
  input  logic [1:0]  st_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  output logic        st_ready_out,
  output logic        stall_out,
  output logic        dmwr_req_out,
  output logic [31:0] dmaddr_out,
  output logic [31:0] dmdata_out,
  output logic [3:0]  dmwr_mask_out,
  input  logic        dmwr_ack_in,
  output logic        misaligned_out,
  output logic        bus_error_out,
  output logic        dbg_state_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic [31:0] fmt_data;
  logic [3:0]  fmt_mask;
  logic        fmt_mis;
  logic        st_ready;
  logic        accept;

  // Lane formatting and misalignment detection for the incoming store.
  always_comb begin
    fmt_data = rs2_in;
    fmt_mask = 4'b1111;
    fmt_mis  = 1'b0;
    case (st_size_in)
      2'b00: begin
        fmt_data = {4{rs2_in[7:0]}};
        fmt_mask = 4'b0001 << iadder_in[1:0];
        fmt_mis  = 1'b0;
      end
      2'b01: begin
        fmt_data = {2{rs2_in[15:0]}};
        fmt_mask = 4'b0011 << {iadder_in[1], 1'b0};
        fmt_mis  = iadder_in[0];
      end
      default: begin
        // Word and reserved sizes behave identically.
        fmt_data = rs2_in;
        fmt_mask = 4'b1111;
        fmt_mis  = |iadder_in[1:0];
      end
    endcase
  end

  // Ready is the only path from dmwr_ack_in; nothing from ack reaches the
  // request output combinationally. In the watchdog's terminal cycle ack is
  // low, so ready is low too; an ack there completes the store normally.
  always_comb begin
    st_ready = 1'b0;
    if (rst_in) begin
      st_ready = (state_q == S_IDLE) ? 1'b1 : dmwr_ack_in;
    end
  end

  assign accept = st_valid_in & st_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    // A rejected store pulses the flag in the cycle after it was taken.
    mis_d   = accept & fmt_mis;
    berr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept && !fmt_mis) begin
          addr_d  = {iadder_in[31:2], 2'b00};
          data_d  = fmt_data;
          mask_d  = fmt_mask;
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmwr_ack_in) begin
          if (accept && !fmt_mis) begin
            // Back-to-back: the next store replaces the completed one.
            addr_d  = {iadder_in[31:2], 2'b00};
            data_d  = fmt_data;
            mask_d  = fmt_mask;
            cnt_d   = 16'd0;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          // Watchdog expired: drop the store, no retry.
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      mask_q  <= 4'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign st_ready_out   = st_ready;
  assign stall_out      = st_valid_in & ~st_ready;
  assign dmwr_req_out   = (state_q == S_WAIT);
  assign dmaddr_out     = addr_q;
  assign dmdata_out     = data_q;
  assign dmwr_mask_out  = mask_q;
  assign misaligned_out = mis_q;
  assign bus_error_out  = berr_q;
  assign dbg_state_out  = state_q;

endmodule
